sync_fifo: RTL and testbench

//   Single-clock FIFO with its own pointer/flag logic around a registered-read RAM.

---
 rtl/sync_fifo_pkg.sv | 29 ++
 rtl/sync_fifo_ram.sv | 36 +++
 rtl/sync_fifo.sv | 111 +++++++++++
 tb/tb_sync_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and flag decoding for the single-clock FIFO.
// The SYNC_FIFO_ERR_EN macro enables sticky overflow/underflow reporting in sync_fifo.
package sync_fifo_pkg;

   localparam int unsigned DEF_DATA_SIZE = 8;
   localparam int unsigned DEF_ADDR_SIZE = 4;
   localparam int unsigned DEPTH         = 1 << DEF_ADDR_SIZE;
   localparam int unsigned PTR_W         = DEF_ADDR_SIZE + 1;

   typedef struct packed {
      logic full;
      logic afull;
      logic empty;
      logic aempty;
   } fifo_flags_t;

   function automatic fifo_flags_t decode_flags(input int unsigned level,
                                                input int unsigned depth,
                                                input int unsigned afull_th,
                                                input int unsigned aempty_th);
      fifo_flags_t f;
      f.full   = (level == depth);
      f.afull  = (level >= afull_th);
      f.empty  = (level == 0);
      f.aempty = (level <= aempty_th);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Single-clock simple dual-port RAM with registered read.
// The array has no reset so it maps to block RAM; only the output register clears.
module sync_fifo_ram #(
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned ADDR_SIZE = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_we,
   input  logic [ADDR_SIZE-1:0] i_waddr,
   input  logic [DATA_SIZE-1:0] i_wdata,
   input  logic                 i_re,
   input  logic [ADDR_SIZE-1:0] i_raddr,
   output logic [DATA_SIZE-1:0] o_rdata
);

   logic [DATA_SIZE-1:0] mem_q [1<<ADDR_SIZE];
   logic [DATA_SIZE-1:0] rdata_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rdata_q <= '0;
      end else if (i_re) begin
         rdata_q <= mem_q[i_raddr];
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, flags and read-valid around sync_fifo_ram.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with i_err_clr.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_SIZE     = 8,
   parameter int unsigned ADDR_SIZE     = 4,
   parameter int unsigned AFULL_THRESH  = 12,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_wr_en,
   input  logic [DATA_SIZE-1:0] i_wdata,
   output logic                 o_full,
   output logic                 o_afull,
   input  logic                 i_rd_en,
   output logic [DATA_SIZE-1:0] o_rdata,
   output logic                 o_rvalid,
   output logic                 o_empty,
   output logic                 o_aempty,
   output logic [ADDR_SIZE:0]   o_level
`ifdef SYNC_FIFO_ERR_EN
   ,
   input  logic                 i_err_clr,
   output logic                 o_overflow,
   output logic                 o_underflow
`endif
);

   localparam int unsigned FDEPTH = 1 << ADDR_SIZE;
   localparam int unsigned FPTR_W = ADDR_SIZE + 1;

   logic [FPTR_W-1:0] wptr_q, wptr_d;
   logic [FPTR_W-1:0] rptr_q, rptr_d;
   logic [FPTR_W-1:0] level;
   logic              rvalid_q;
   logic              wr_acc;
   logic              rd_acc;
   fifo_flags_t       flags;

   // Pointer MSB distinguishes full from empty; modulo subtraction gives occupancy.
   assign level  = wptr_q - rptr_q;
   assign flags  = decode_flags({{(32-FPTR_W){1'b0}}, level}, FDEPTH,
                                AFULL_THRESH, AEMPTY_THRESH);
   assign wr_acc = i_wr_en & ~flags.full;
   assign rd_acc = i_rd_en & ~flags.empty;

   always_comb begin
      wptr_d = wptr_q + FPTR_W'(wr_acc);
      rptr_d = rptr_q + FPTR_W'(rd_acc);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         rvalid_q <= rd_acc;
      end
   end

   sync_fifo_ram #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_we    (wr_acc),
      .i_waddr (wptr_q[ADDR_SIZE-1:0]),
      .i_wdata (i_wdata),
      .i_re    (rd_acc),
      .i_raddr (rptr_q[ADDR_SIZE-1:0]),
      .o_rdata (o_rdata)
   );

   assign o_full   = flags.full;
   assign o_afull  = flags.afull;
   assign o_empty  = flags.empty;
   assign o_aempty = flags.aempty;
   assign o_level  = level;
   assign o_rvalid = rvalid_q;

`ifdef SYNC_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   // A new error on the clearing edge takes priority over the clear.
   always_comb begin
      ovf_d = (i_wr_en & flags.full)  | (ovf_q & ~i_err_clr);
      unf_d = (i_rd_en & flags.empty) | (unf_q & ~i_err_clr);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign o_overflow  = ovf_q;
   assign o_underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vectors, corner sequences and a
// queue-based reference model under random traffic.
module tb_sync_fifo;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;
   localparam int AF = 12;
   localparam int AE = 2;

   logic          i_clk = 1'b0;
   logic          i_rstn = 1'b0;
   logic          i_wr_en = 1'b0;
   logic [DW-1:0] i_wdata = '0;
   logic          i_rd_en = 1'b0;
   logic          o_full, o_afull, o_rvalid, o_empty, o_aempty;
   logic [DW-1:0] o_rdata;
   logic [AW:0]   o_level;
   logic          err_clr = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
   logic          o_overflow, o_underflow;
`endif

   sync_fifo #(
      .DATA_SIZE     (DW),
      .ADDR_SIZE     (AW),
      .AFULL_THRESH  (AF),
      .AEMPTY_THRESH (AE)
   ) dut (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_wr_en  (i_wr_en),
      .i_wdata  (i_wdata),
      .o_full   (o_full),
      .o_afull  (o_afull),
      .i_rd_en  (i_rd_en),
      .o_rdata  (o_rdata),
      .o_rvalid (o_rvalid),
      .o_empty  (o_empty),
      .o_aempty (o_aempty),
      .o_level  (o_level)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .i_err_clr   (err_clr),
      .o_overflow  (o_overflow),
      .o_underflow (o_underflow)
`endif
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: contents as a queue plus the expected read port.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_rdata = '0;
   logic          m_rvalid = 1'b0;
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
   endtask

   task automatic model_step(input logic wr, input logic rd, input logic [DW-1:0] d,
                             input logic clr);
      int sz;
      sz = mq.size();
      m_ovf = (wr && sz == DEPTH) || (m_ovf && !clr);
      m_unf = (rd && sz == 0) || (m_unf && !clr);
      if (rd && sz > 0) begin
         m_rdata  = mq.pop_front();
         m_rvalid = 1'b1;
      end else begin
         m_rvalid = 1'b0;
      end
      if (wr && sz < DEPTH) mq.push_back(d);
   endtask

   task automatic compare_all();
      int sz;
      sz = mq.size();
      check("level",  32'(o_level),  32'(sz));
      check("empty",  32'(o_empty),  32'(sz == 0));
      check("full",   32'(o_full),   32'(sz == DEPTH));
      check("afull",  32'(o_afull),  32'(sz >= AF));
      check("aempty", 32'(o_aempty), 32'(sz <= AE));
      check("rvalid", 32'(o_rvalid), 32'(m_rvalid));
      check("rdata",  32'(o_rdata),  32'(m_rdata));
`ifdef SYNC_FIFO_ERR_EN
      check("overflow",  32'(o_overflow),  32'(m_ovf));
      check("underflow", 32'(o_underflow), 32'(m_unf));
`endif
   endtask

   task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d,
                        input logic clr);
      i_wr_en = wr;
      i_rd_en = rd;
      i_wdata = d;
      err_clr = clr;
      @(posedge i_clk);
      model_step(wr, rd, d, clr);
      #1;
      i_wr_en = 1'b0;
      i_rd_en = 1'b0;
      err_clr = 1'b0;
      compare_all();
   endtask

   // Asynchronous assert away from the edge, release on a falling edge.
   task automatic reset_mid_clock();
      @(posedge i_clk);
      #3;
      i_rstn = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rstn = 1'b1;
   endtask

   typedef struct {
      logic          wr;
      logic          rd;
      logic [DW-1:0] d;
      int            lvl;
      logic          rv;
      logic [DW-1:0] rdat;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'hA1, 1, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 8'hB2, 2, 1'b0, 8'h00};
      tbl[2] = '{1'b1, 1'b1, 8'hC3, 2, 1'b1, 8'hA1};
      tbl[3] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'hB2};
      tbl[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hC3};
      tbl[5] = '{1'b1, 1'b1, 8'hD4, 1, 1'b0, 8'hC3};
      tbl[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hD4};
      tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hD4};

      // Power-on reset
      model_reset();
      #2;
      compare_all();
      @(negedge i_clk);
      @(negedge i_clk);
      i_rstn = 1'b1;

      // Directed vectors, including write+read on an empty FIFO
      foreach (tbl[k]) begin
         cycle(tbl[k].wr, tbl[k].rd, tbl[k].d, 1'b0);
         check("tbl_level",  32'(o_level),  32'(tbl[k].lvl));
         check("tbl_rvalid", 32'(o_rvalid), 32'(tbl[k].rv));
         check("tbl_rdata",  32'(o_rdata),  32'(tbl[k].rdat));
      end

      // Mid-clock reset with non-zero state
      cycle(1'b1, 1'b0, 8'h11, 1'b0);
      cycle(1'b1, 1'b1, 8'h22, 1'b0);
      reset_mid_clock();
      check("rst_level", 32'(o_level), 32'd0);

      // Fill to full, then one rejected write; flags swept on the way up
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
      cycle(1'b1, 1'b0, 8'hAA, 1'b0);
      check("full_after_17", 32'(o_full), 32'd1);
      check("level_after_17", 32'(o_level), 32'd16);

      // Drain, checking order; then one rejected read and an error clear
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0);
         check("drain_rdata", 32'(o_rdata), 32'(i));
      end
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("extra_rd_rvalid", 32'(o_rvalid), 32'd0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);

      // Full + write + read: read taken, write dropped
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
      cycle(1'b1, 1'b1, 8'hEE, 1'b0);
      check("full_rw_rdata", 32'(o_rdata), 32'h40);
      while (mq.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);

      // Steady level 8 with simultaneous traffic, pointers wrap
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
      for (int i = 8; i < 48; i++) begin
         cycle(1'b1, 1'b1, DW'(i), 1'b0);
         check("steady_level", 32'(o_level), 32'd8);
         check("steady_rdata", 32'(o_rdata), 32'(i - 8));
      end
      while (mq.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);

      // Reset with a read in flight, then recover
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, DW'(8'h70 + i), 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      #2;
      i_rstn = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge i_clk);
      i_rstn = 1'b1;
      cycle(1'b1, 1'b0, 8'h5A, 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("post_rst_rdata", 32'(o_rdata), 32'h5A);

      // Random traffic in write-heavy, read-heavy and balanced phases
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 150; i++) begin
            logic wr, rd, clr;
            wr  = ($urandom_range(0, 99) < (ph == 0 ? 80 : (ph == 1 ? 20 : 50)));
            rd  = ($urandom_range(0, 99) < (ph == 0 ? 20 : (ph == 1 ? 80 : 50)));
            clr = ($urandom_range(0, 15) == 0);
            cycle(wr, rd, DW'($urandom), clr);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
